// File: rtl/short_t_pkg.sv
// short_t_pkg: FSM states and default constants shared by the short_t pulse qualifier.
package short_t_pkg;
  typedef enum logic [1:0] {WAIT_LOW, IDLE, QUALIFY, HIGH} state_t;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int MIN_WIDTH_DEF = 4;
  localparam int WIDTH_W_DEF = 16;
  localparam int GLITCH_MAX = 255;
endpackage

// File: rtl/short_t_sync_chain.sv
// sync_chain: multi-flop synchronizer for an asynchronous level, resetting to 1.
module sync_chain #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [SYNC_STAGES-1:0] ff;
  always_ff @(posedge clk)
    ff <= rst ? '1 : {ff[SYNC_STAGES-2:0], d};
  assign q = ff[SYNC_STAGES-1];
endmodule

// File: rtl/short_t.sv
// short_t: qualifies stretched async pulses, counts glitches; width measurement under SHORT_T_WIDTH_MEAS_EN.
module short_t
  import short_t_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int MIN_WIDTH = MIN_WIDTH_DEF,
  parameter int WIDTH_W = WIDTH_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_level,
  output logic               out_pulse,
  output logic [WIDTH_W-1:0] width,
  output logic               width_valid,
  output logic [7:0]         glitch_cnt
);
  localparam int MW = $clog2(MIN_WIDTH + 1);
`ifdef SHORT_T_WIDTH_MEAS_EN
  localparam int CW = WIDTH_W > MW ? WIDTH_W : MW;
  localparam logic [CW-1:0] SAT = CW'((64'd1 << WIDTH_W) - 64'd1);
`else
  localparam int CW = MW;
`endif
  localparam logic [CW-1:0] MIN_C = CW'(MIN_WIDTH);
  logic s;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic pulse_n;
  logic [7:0] glitch_n;
  logic wv_n;
  logic [WIDTH_W-1:0] width_n;
  sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (.clk(clk), .rst(rst), .d(in_level), .q(s));
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    pulse_n = 1'b0;
    glitch_n = glitch_cnt;
    wv_n = 1'b0;
    width_n = width;
    case (state)
      WAIT_LOW: state_n = s ? WAIT_LOW : IDLE;
      IDLE: if (s) begin
        cnt_n = CW'(1);
        state_n = MIN_WIDTH == 1 ? HIGH : QUALIFY;
        pulse_n = MIN_WIDTH == 1;
      end
      QUALIFY: if (s) begin
        cnt_n = cnt + CW'(1);
        state_n = cnt_n == MIN_C ? HIGH : QUALIFY;
        pulse_n = cnt_n == MIN_C;
      end else begin
        state_n = IDLE;
        glitch_n = glitch_cnt + {7'd0, glitch_cnt != 8'(GLITCH_MAX)};
      end
`ifdef SHORT_T_WIDTH_MEAS_EN
      HIGH: if (s)
        cnt_n = cnt >= SAT ? cnt : cnt + CW'(1);
      else begin
        state_n = IDLE;
        wv_n = 1'b1;
        width_n = cnt >= SAT ? '1 : cnt[WIDTH_W-1:0];
      end
`else
      HIGH: state_n = s ? HIGH : IDLE;
`endif
      default: state_n = WAIT_LOW;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= WAIT_LOW;
      cnt <= '0;
      out_pulse <= 1'b0;
      glitch_cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      out_pulse <= pulse_n;
      glitch_cnt <= glitch_n;
    end
`ifdef SHORT_T_WIDTH_MEAS_EN
  always_ff @(posedge clk)
    if (rst) begin
      width <= '0;
      width_valid <= 1'b0;
    end else begin
      width <= width_n;
      width_valid <= wv_n;
    end
`else
  assign width = '0;
  assign width_valid = 1'b0;
`endif
endmodule
